hpdcache_snoop_rsp_serializer: RTL and testbench

// - Sits between the cache's snoop handler and the ACE snoop adapter; feeds its snoop_rsp_meta/snoop_rsp_data inputs.
// - Takes one snoop response per transaction (meta + full cache line) and issues meta once on the CR-side channel.
// - Serialises the line into NumBeats data beats on the CD-side channel, with `last` on the final beat.
// - Meta and data channels handshake independently; the line is registered, so the snoop handler is freed after one cycle.

---
 rtl/hpdcache_pkg.sv | 28 ++
 rtl/hpdcache_snoop_rsp_serializer.sv | 118 +++++++++++
 tb/tb_hpdcache_snoop_rsp_serializer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/hpdcache_pkg.sv
// Shared HPDcache types used on the snoop response path.
// Holds the cache config, snoop meta and snoop data beat.
package hpdcache_pkg;

  typedef struct packed {
    int unsigned clOffsetWidth;
  } hpdcache_cfg_t;

  localparam hpdcache_cfg_t HPDCACHE_DEFAULT_CFG = '{
    clOffsetWidth: 6
  };

  localparam int unsigned HPDCACHE_SNOOP_BEAT_W = 64;

  typedef struct packed {
    logic was_unique;
    logic is_shared;
    logic pass_dirty;
    logic error;
    logic data_transfer;
  } hpdcache_snoop_meta_t;

  typedef struct packed {
    logic [HPDCACHE_SNOOP_BEAT_W-1:0] data;
    logic                             last;
  } hpdcache_snoop_beat_t;

endpackage

// File: rtl/hpdcache_snoop_rsp_serializer.sv
// Registers one snoop response, then issues its meta once
// and its cache line as NumBeats beats on independent channels.
module hpdcache_snoop_rsp_serializer
  import hpdcache_pkg::*;
#(
  parameter hpdcache_cfg_t HPDcacheCfg = HPDCACHE_DEFAULT_CFG,
  parameter int unsigned CacheLineWidth =
    8 << HPDcacheCfg.clOffsetWidth,
  parameter int unsigned BeatWidth = 64,
  parameter type hpdcache_snoop_resp_data_t =
    hpdcache_snoop_beat_t
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      snoop_rsp_valid_i,
  output logic                      snoop_rsp_ready_o,
  input  hpdcache_snoop_meta_t      snoop_rsp_meta_i,
  input  logic [CacheLineWidth-1:0] snoop_rsp_line_i,
  output logic                      snoop_rsp_meta_valid_o,
  input  logic                      snoop_rsp_meta_ready_i,
  output hpdcache_snoop_meta_t      snoop_rsp_meta_o,
  output logic                      snoop_rsp_data_valid_o,
  input  logic                      snoop_rsp_data_ready_i,
  output hpdcache_snoop_resp_data_t snoop_rsp_data_o
);

  localparam int unsigned NumBeats =
    CacheLineWidth / BeatWidth;
  localparam int unsigned CntW =
    (NumBeats > 1) ? $clog2(NumBeats) : 1;

  typedef logic [CntW-1:0] beat_cnt_t;

  localparam beat_cnt_t LastBeat =
    beat_cnt_t'(NumBeats - 1);

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

  state_t                    r_state;
  logic                      r_meta_pend;
  logic                      r_data_pend;
  beat_cnt_t                 r_beat;
  hpdcache_snoop_meta_t      r_meta;
  logic [CacheLineWidth-1:0] r_line;

  logic                      w_accept;
  logic                      w_meta_hs;
  logic                      w_data_hs;
  logic                      w_last;
  logic                      w_meta_pend_n;
  logic                      w_data_pend_n;
  logic [CacheLineWidth-1:0] w_line_sh;

  assign w_accept = snoop_rsp_valid_i
                  & (r_state == ST_IDLE);
  assign w_meta_hs = r_meta_pend
                   & snoop_rsp_meta_ready_i;
  assign w_data_hs = r_data_pend
                   & snoop_rsp_data_ready_i;
  assign w_last = (r_beat == LastBeat);

  assign w_meta_pend_n = r_meta_pend & ~w_meta_hs;
  assign w_data_pend_n = r_data_pend
                       & ~(w_data_hs & w_last);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_meta_pend <= 1'b0;
      r_data_pend <= 1'b0;
      r_beat      <= '0;
      r_meta      <= '0;
      r_line      <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_meta      <= snoop_rsp_meta_i;
            r_line      <= snoop_rsp_line_i;
            r_meta_pend <= 1'b1;
            r_data_pend <= snoop_rsp_meta_i.data_transfer;
            r_beat      <= '0;
            r_state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_meta_pend <= w_meta_pend_n;
          r_data_pend <= w_data_pend_n;
          if (w_data_hs) begin
            r_beat <= w_last ? '0 : r_beat + 1'b1;
          end
          // leave as soon as the final handshake lands
          if (!w_meta_pend_n && !w_data_pend_n) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign snoop_rsp_ready_o      = (r_state == ST_IDLE);
  assign snoop_rsp_meta_valid_o = r_meta_pend;
  assign snoop_rsp_meta_o       = r_meta;
  assign snoop_rsp_data_valid_o = r_data_pend;

  assign w_line_sh = r_line >> (r_beat * BeatWidth);

  always_comb begin
    snoop_rsp_data_o      = '0;
    snoop_rsp_data_o.data = w_line_sh[BeatWidth-1:0];
    snoop_rsp_data_o.last = w_last;
  end

endmodule

// File: tb/tb_hpdcache_snoop_rsp_serializer.sv
// Bench for the snoop response serializer: directed cases plus
// random traffic against a queue-based model of meta and beats.
module tb_hpdcache_snoop_rsp_serializer;
  import hpdcache_pkg::*;

  localparam int CLW = 512;
  localparam int BW  = 64;
  localparam int NB  = CLW / BW;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  hpdcache_snoop_meta_t in_meta = '0;
  logic [CLW-1:0]       in_line = '0;
  logic                 mv;
  logic                 mr = 1'b0;
  hpdcache_snoop_meta_t mo;
  logic                 dv;
  logic                 dr = 1'b0;
  hpdcache_snoop_beat_t dout;

  int checks = 0;
  int errors = 0;

  bit                   m_meta_pend = 1'b0;
  hpdcache_snoop_meta_t m_meta = '0;
  logic [BW:0]          m_beats[$];

  always #5 clk = ~clk;

  hpdcache_snoop_rsp_serializer dut (
    .clk_i                  (clk),
    .rst_ni                 (rst_n),
    .snoop_rsp_valid_i      (in_valid),
    .snoop_rsp_ready_o      (in_ready),
    .snoop_rsp_meta_i       (in_meta),
    .snoop_rsp_line_i       (in_line),
    .snoop_rsp_meta_valid_o (mv),
    .snoop_rsp_meta_ready_i (mr),
    .snoop_rsp_meta_o       (mo),
    .snoop_rsp_data_valid_o (dv),
    .snoop_rsp_data_ready_i (dr),
    .snoop_rsp_data_o       (dout)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic bit busy();
    return m_meta_pend || (m_beats.size() != 0);
  endfunction

  // one clock: drive at negedge, check, advance model
  task automatic step(input bit v,
                      input hpdcache_snoop_meta_t m,
                      input logic [CLW-1:0] ln,
                      input bit r_m,
                      input bit r_d);
    bit b;
    @(negedge clk);
    in_valid = v;
    in_meta  = m;
    in_line  = ln;
    mr       = r_m;
    dr       = r_d;
    #1;
    b = busy();
    chk("ready", 64'(in_ready), 64'(!b));
    chk("meta_valid", 64'(mv), 64'(m_meta_pend));
    if (m_meta_pend)
      chk("meta", 64'(mo), 64'(m_meta));
    chk("data_valid", 64'(dv),
        64'(m_beats.size() != 0));
    if (m_beats.size() != 0) begin
      chk("beat_data", dout.data, m_beats[0][BW:1]);
      chk("beat_last", 64'(dout.last),
          64'(m_beats[0][0]));
    end
    if (!b) begin
      if (v) begin
        m_meta_pend = 1'b1;
        m_meta = m;
        if (m.data_transfer)
          for (int i = 0; i < NB; i++)
            m_beats.push_back({ln[i*BW +: BW],
                               i == NB - 1});
      end
    end else begin
      if (m_meta_pend && r_m)
        m_meta_pend = 1'b0;
      if (m_beats.size() != 0 && r_d)
        void'(m_beats.pop_front());
    end
  endtask

  task automatic idle(input int n,
                      input bit r_m,
                      input bit r_d);
    for (int i = 0; i < n; i++)
      step(1'b0, '0, '0, r_m, r_d);
  endtask

  task automatic rst_checks(input string tag);
    chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_mvalid"}, 64'(mv), 64'd0);
    chk({tag, "_dvalid"}, 64'(dv), 64'd0);
    chk({tag, "_meta"}, 64'(mo), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    m_meta_pend = 1'b0;
    m_beats.delete();
    rst_checks("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    rst_checks("rel");
  endtask

  task automatic drain(input string tag);
    int g = 0;
    while (busy() && g < 200) begin
      step(1'b0, '0, '0, 1'b1, 1'b1);
      g++;
    end
    chk({tag, "_drain"}, 64'(busy()), 64'd0);
  endtask

  function automatic logic [CLW-1:0] rand_line();
    logic [CLW-1:0] l;
    for (int w = 0; w < CLW / 32; w++)
      l[w*32 +: 32] = $urandom;
    return l;
  endfunction

  initial begin
    hpdcache_snoop_meta_t m;
    logic [CLW-1:0]       ln;
    bit                   acc;
    int                   g;

    do_reset();
    idle(3, 1'b1, 1'b1);

    // full transfer, adapter always ready
    m = '0;
    m.pass_dirty = 1'b1;
    m.data_transfer = 1'b1;
    for (int i = 0; i < NB; i++)
      ln[i*BW +: BW] = 64'h1111_0000 + 64'(i);
    step(1'b1, m, ln, 1'b1, 1'b1);
    idle(9, 1'b1, 1'b1);

    // meta-only
    m = '0;
    m.is_shared = 1'b1;
    step(1'b1, m, rand_line(), 1'b1, 1'b1);
    idle(2, 1'b1, 1'b1);

    // backpressure on both channels
    m = '0;
    m.was_unique = 1'b1;
    m.data_transfer = 1'b1;
    step(1'b1, m, rand_line(), 1'b0, 1'b0);
    for (int c = 0; c < 20; c++)
      step(1'b1, '1, rand_line(), 1'b0,
           (c % 2) == 0);
    drain("bp");
    idle(1, 1'b1, 1'b1);

    // final meta and final beat in one cycle
    m = '0;
    m.data_transfer = 1'b1;
    step(1'b1, m, rand_line(), 1'b0, 1'b1);
    for (int k = 1; k <= NB; k++)
      step(1'b0, '0, '0, k == NB, 1'b1);
    idle(1, 1'b1, 1'b1);

    // async reset after beat 3
    step(1'b1, m, rand_line(), 1'b0, 1'b1);
    idle(4, 1'b0, 1'b1);
    do_reset();
    step(1'b1, m, rand_line(), 1'b1, 1'b1);
    drain("post_rst");
    idle(1, 1'b1, 1'b1);

    // error bit does not suppress data
    m = '0;
    m.error = 1'b1;
    m.data_transfer = 1'b1;
    step(1'b1, m, rand_line(), 1'b1, 1'b1);
    drain("err");
    idle(1, 1'b1, 1'b1);

    // random traffic with random backpressure
    for (int n = 0; n < 40; n++) begin
      m  = hpdcache_snoop_meta_t'(5'($urandom));
      ln = rand_line();
      g  = 0;
      do begin
        acc = !busy();
        step(1'b1, m, ln,
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
        g++;
      end while (!acc && g < 50);
      g = 0;
      while (busy() && g < 300) begin
        step(1'($urandom_range(0, 1)),
             hpdcache_snoop_meta_t'(5'($urandom)),
             rand_line(),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
        g++;
      end
      chk("rand_done", 64'(busy()), 64'd0);
      if ($urandom_range(0, 3) == 0)
        idle(1, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
